// File: rtl/regwr_pkg.sv
// Shared widths, XZR address and the registered write-command payload
// for the register-file write-port arbiter.
package regwr_pkg;

    localparam int unsigned DATA_W   = 64;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned CNT_W    = 16;

    localparam logic [ADDR_W-1:0] XZR_ADDR = 5'd31;

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_cmd_t;

endpackage

// File: rtl/regwr_if.sv
// Writeback request bundle: requesters drive req/waddr/wdata and the
// datapath stall; the arbiter returns a combinational one-hot grant.
interface regwr_if
    import regwr_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF
) ();

    logic                             stall;
    logic [NREQ-1:0]                  req;
    logic [NREQ-1:0][ADDR_W-1:0]      waddr;
    logic [NREQ-1:0][DATA_W-1:0]      wdata;
    logic [NREQ-1:0]                  gnt;

    modport master (
        output stall,
        output req,
        output waddr,
        output wdata,
        input  gnt
    );

    modport slave (
        input  stall,
        input  req,
        input  waddr,
        input  wdata,
        output gnt
    );

endinterface

// File: rtl/rr_pick.sv
// Rotate-and-priority-encode: one-hot pick of the first set request
// searching upward from ptr_i, wrapping from NREQ-1 back to 0.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_c
);

    logic [PW:0] idx;
    logic        found;

    // Walk NREQ positions starting at ptr_i; the first pending one wins.
    always_comb begin
        gnt_c = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr_i} + (PW+1)'(k);
            if (idx >= (PW+1)'(NREQ)) begin
                idx = idx - (PW+1)'(NREQ);
            end
            if (!found && req_i[idx[PW-1:0]]) begin
                gnt_c[idx[PW-1:0]] = 1'b1;
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regwr_arbiter.sv
// Register-file write-port arbiter: grants at most one writeback request
// per cycle, discards writes to XZR (counting them) and registers the
// resulting write command.
// Build option: RR_PRIORITY_EN selects round-robin arbitration with a
// rotating pointer; without it the lowest pending index always wins.
module regwr_arbiter
    import regwr_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF
) (
    input  logic              clk,
    input  logic              reset,
    regwr_if.slave            wb,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam int unsigned PW = $clog2(NREQ);

    logic [PW-1:0]     ptr_cur;
    logic [NREQ-1:0]   pick_c;
    logic [NREQ-1:0]   gnt_c;
    logic              gnt_any;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    wr_cmd_t           cmd_q, cmd_d;
    logic [CNT_W-1:0]  drop_q, drop_d;

`ifdef RR_PRIORITY_EN
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     gidx;

    assign ptr_cur = ptr_q;

    // Index of the granted requester and the pointer position just past it.
    always_comb begin
        gidx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_c[i]) begin
                gidx = PW'(i);
            end
        end
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
        end
    end

    // Round-robin pointer, cleared by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign ptr_cur = '0;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req_i (wb.req),
        .ptr_i (ptr_cur),
        .gnt_c (pick_c)
    );

    // Suppress the grant while stalled or held in reset.
    always_comb begin
        gnt_c = '0;
        if (reset && !wb.stall) begin
            gnt_c = pick_c;
        end
    end

    assign wb.gnt  = gnt_c;
    assign gnt_any = |gnt_c;

    // Mux out the granted requester's address and data (grant is one-hot).
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_c[i]) begin
                sel_addr = sel_addr | wb.waddr[i];
                sel_data = sel_data | wb.wdata[i];
            end
        end
    end

    // Next write command and saturating XZR drop count.
    always_comb begin
        cmd_d    = cmd_q;
        cmd_d.en = 1'b0;
        drop_d   = drop_q;
        if (gnt_any) begin
            cmd_d.addr = sel_addr;
            cmd_d.data = sel_data;
            cmd_d.en   = (sel_addr != XZR_ADDR);
            if ((sel_addr == XZR_ADDR) && (drop_q != '1)) begin
                drop_d = drop_q + CNT_W'(1);
            end
        end
    end

    // Output command register (flopr style, async clear).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_q  <= '0;
            drop_q <= '0;
        end else begin
            cmd_q  <= cmd_d;
            drop_q <= drop_d;
        end
    end

    assign wr_en    = cmd_q.en;
    assign wr_addr  = cmd_q.addr;
    assign wr_data  = cmd_q.data;
    assign drop_cnt = drop_q;

endmodule
